// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, forward selects, flush mask.
// Pure declarations; no logic of its own.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_LDUSE = 2'b01,
        ST_MWAIT = 2'b10,
        ST_FLUSH = 2'b11
    } state_t;

    localparam logic [1:0] FWD_RF     = 2'b00;
    localparam logic [1:0] FWD_EX     = 2'b01;
    localparam logic [1:0] FWD_MEMALU = 2'b10;
    localparam logic [1:0] FWD_MEMLD  = 2'b11;

    // bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM; squash the youngest 'depth' stages
    function automatic logic [2:0] flush_mask(input int depth);
        logic [2:0] m;
        for (int i = 0; i < 3; i++) begin
            m[i] = (i < depth);
        end
        return m;
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Operand forward select for one ID source register; purely combinational.
// EX wins over MEM; an EX load cannot forward yet and reads the regfile while the stall covers it.
module fwd_sel
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              i_use,
    input  logic [REG_AW-1:0] i_src,
    input  logic [REG_AW-1:0] i_ex_wn,
    input  logic              i_ex_wreg,
    input  logic              i_ex_m2reg,
    input  logic [REG_AW-1:0] i_mem_wn,
    input  logic              i_mem_wreg,
    input  logic              i_mem_m2reg,
    output logic [1:0]        o_sel
);

    logic w_ex_hit;
    logic w_mem_hit;

    assign w_ex_hit  = i_use && i_ex_wreg  && (i_ex_wn  != '0) && (i_src == i_ex_wn);
    assign w_mem_hit = i_use && i_mem_wreg && (i_mem_wn != '0) && (i_src == i_mem_wn);

    always_comb begin
        o_sel = FWD_RF;
        if (w_ex_hit) begin
            o_sel = i_ex_m2reg ? FWD_RF : FWD_EX;
        end else if (w_mem_hit) begin
            o_sel = i_mem_m2reg ? FWD_MEMLD : FWD_MEMALU;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctl.sv
// 5-stage pipeline hazard control: forwarding, load-use bubble, memory-wait freeze, branch flush.
// All control outputs are Mealy in the decision cycle; only state and stall_cnt are registered.
module pipe_hazard_ctl
    import pipe_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int FLUSH_DEPTH = 3,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] ex_wn,
    input  logic [REG_AW-1:0] mem_wn,
    input  logic              ex_wreg,
    input  logic              mem_wreg,
    input  logic              ex_m2reg,
    input  logic              mem_m2reg,
    input  logic              mem_ready,
    input  logic              br_taken,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              idex_bubble,
    output logic [2:0]        flush,
    output logic              freeze,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [2:0] C_FLUSH_MASK = flush_mask(FLUSH_DEPTH);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic               w_load_use;
    logic               w_mem_wait;

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .i_use       (id_use_rs),
        .i_src       (id_rs),
        .i_ex_wn     (ex_wn),
        .i_ex_wreg   (ex_wreg),
        .i_ex_m2reg  (ex_m2reg),
        .i_mem_wn    (mem_wn),
        .i_mem_wreg  (mem_wreg),
        .i_mem_m2reg (mem_m2reg),
        .o_sel       (fwd_a)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .i_use       (id_use_rt),
        .i_src       (id_rt),
        .i_ex_wn     (ex_wn),
        .i_ex_wreg   (ex_wreg),
        .i_ex_m2reg  (ex_m2reg),
        .i_mem_wn    (mem_wn),
        .i_mem_wreg  (mem_wreg),
        .i_mem_m2reg (mem_m2reg),
        .o_sel       (fwd_b)
    );

    assign w_load_use = ex_m2reg && ex_wreg && (ex_wn != '0) &&
                        ((id_use_rs && (id_rs == ex_wn)) || (id_use_rt && (id_rt == ex_wn)));

    // Data memory holds mem_ready high whenever MEM has no load/store outstanding,
    // so a low level always means the MEM access has not completed.
    assign w_mem_wait = !mem_ready;

    // Priority: memory wait > taken branch > load-use. In LDUSE the load has moved
    // to MEM, so a stale EX view of it must not raise a second bubble.
    always_comb begin
        w_next      = ST_RUN;
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_bubble = 1'b0;
        flush       = 3'b000;
        freeze      = 1'b0;
        if (w_mem_wait) begin
            w_next  = ST_MWAIT;
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            freeze  = 1'b1;
        end else if (br_taken) begin
            w_next = ST_FLUSH;
            flush  = C_FLUSH_MASK;
        end else if (w_load_use && (r_state != ST_LDUSE)) begin
            w_next      = ST_LDUSE;
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state     <= ST_RUN;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (!pc_we && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign state     = r_state;
    assign stall_cnt = r_stall_cnt;

endmodule
